// File: rtl/data_bus_slave_pkg.sv
// data_bus_slave_pkg: shared constants and the address decoder for the data bus responder.
//   RegBus          : bus data width.
//   DbusMmioBase    : base of the 4 KiB MMIO window.
//   Dbus*Off        : register offsets within the window.
//   dbus_decode()   : maps a word address (addr[31:2]) onto a target select.
package data_bus_slave_pkg;

  localparam int          RegBus       = 32;
  localparam logic [31:0] DbusMmioBase = 32'hFFFF_F000;
  localparam logic [11:0] DbusLedOff   = 12'h000;
  localparam logic [11:0] DbusSwOff    = 12'h004;
  localparam logic [11:0] DbusTimerOff = 12'h008;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,  // unmapped MMIO offset
    SEL_RAM   = 3'd1,
    SEL_LED   = 3'd2,
    SEL_SW    = 3'd3,
    SEL_TIMER = 3'd4
  } dbus_sel_e;

  // Anything outside the top 4 KiB page is RAM; inside it only three words are live.
  function automatic dbus_sel_e dbus_decode(input logic [29:0] waddr);
    logic [11:0] off;
    off = {waddr[9:0], 2'b00};
    if (waddr[29:10] != DbusMmioBase[31:12]) return SEL_RAM;
    case (off)
      DbusLedOff:   return SEL_LED;
      DbusSwOff:    return SEL_SW;
      DbusTimerOff: return SEL_TIMER;
      default:      return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_slave_sw_debounce.sv
// sw_debounce: per-bit 2-flop synchronizer followed by a stability counter.
//   clk  : system clock.
//   rst  : asynchronous active-low reset.
//   din  : asynchronous input pins.
//   dout : debounced value; a bit flips once its synced input has differed
//          from it for CYCLES consecutive cycles (pin-to-dout latency 2+CYCLES).
module sw_debounce #(
  parameter int WIDTH  = 12,
  parameter int CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, stable_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stb_d;

    always_comb begin
      cnt_d = '0;
      stb_d = stable_q[i];
      // Any cycle where the input agrees with the accepted value restarts the window,
      // so a glitch shorter than CYCLES never gets through.
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q == CNT_MAX) stb_d = sync2_q[i];
        else                  cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q       <= '0;
        stable_q[i] <= 1'b0;
      end else begin
        cnt_q       <= cnt_d;
        stable_q[i] <= stb_d;
      end
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/data_bus_slave.sv
// data_bus_slave: responder for the core's data-memory port.
//   clk, rst   : clock and asynchronous active-low reset.
//   ce, we     : access strobe and write enable (write qualified by ce).
//   addr       : byte address, bits [1:0] ignored.
//   wdata      : write data.
//   rdata      : combinational read data, zero unless ce=1 and we=0.
//   sw_raw     : asynchronous switch pins.
//   led        : LED register.
//   sw_stable  : debounced switches.
// Map: 0xFFFF_F000 LED (RW), +4 SWITCH (RO), +8 TIMER (RW); everything outside
// the 0xFFFFF page is RAM, aliased modulo RAM_WORDS.
// Optional macro DBUS_TIMER_EN: when undefined the timer is absent and +8 reads 0.
module data_bus_slave
  import data_bus_slave_pkg::*;
#(
  parameter int          RAM_WORDS       = 1024,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] LED_RESET       = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] rdata,
  input  logic [11:0]       sw_raw,
  output logic [31:0]       led,
  output logic [11:0]       sw_stable
);

  localparam int AW = $clog2(RAM_WORDS);

  dbus_sel_e         sel;
  logic              wr_en;
  logic [AW-1:0]     ram_idx;
  logic [RegBus-1:0] mem [RAM_WORDS];
  logic [31:0]       led_q, led_d;
  logic [31:0]       timer_rd;
  logic              unused_addr;

  assign sel         = dbus_decode(addr[31:2]);
  assign wr_en       = ce & we;
  assign ram_idx     = addr[AW+1:2];
  assign unused_addr = ^addr[1:0];

  // RAM: no reset, write on the edge of a qualified write.
  always_ff @(posedge clk) begin
    if (wr_en && sel == SEL_RAM) mem[ram_idx] <= wdata;
  end

  always_comb begin
    led_d = led_q;
    if (wr_en && sel == SEL_LED) led_d = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_q <= LED_RESET;
    else      led_q <= led_d;
  end

`ifdef DBUS_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // A load wins over the increment, so the loaded value is visible for one cycle.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr_en && sel == SEL_TIMER) timer_d = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timer_q <= '0;
    else      timer_q <= timer_d;
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  sw_debounce #(
    .WIDTH  (12),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (sw_raw),
    .dout (sw_stable)
  );

  // Read path is zero-wait: the core's MEM stage samples rdata in the same cycle.
  always_comb begin
    rdata = '0;
    if (ce && !we) begin
      case (sel)
        SEL_RAM:   rdata = mem[ram_idx];
        SEL_LED:   rdata = led_q;
        SEL_SW:    rdata = {20'b0, sw_stable};
        SEL_TIMER: rdata = timer_rd;
        default:   rdata = '0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_data_bus_slave.sv
module tb_data_bus_slave;

  localparam logic [31:0] LED_RST = 32'h0000_0F0F;
  localparam logic [31:0] A_LED   = 32'hFFFF_F000;
  localparam logic [31:0] A_SW    = 32'hFFFF_F004;
  localparam logic [31:0] A_TMR   = 32'hFFFF_F008;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, wdata, rdata, led;
  logic [11:0] sw_raw, sw_stable;
  logic [31:0] v;

  int n_cmp = 0;
  int n_err = 0;

  data_bus_slave #(
    .RAM_WORDS       (1024),
    .DEBOUNCE_CYCLES (8),
    .LED_RESET       (LED_RST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .sw_raw    (sw_raw),
    .led       (led),
    .sw_stable (sw_stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    ce = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw_raw = '0;
    tick(2);
    chk("rst_led", led, LED_RST);
    chk("rst_sw", {20'b0, sw_stable}, 32'h0);
    rst = 1'b1;

    // Reads right after reset release, before any edge advances the timer.
    bus_rd(A_LED, v); chk("rd_led_rst", v, LED_RST);
    bus_rd(A_SW, v);  chk("rd_sw_rst", v, 32'h0);
    bus_rd(A_TMR, v); chk("rd_tmr_rst", v, 32'h0);

    // RAM write/read, aliasing, ignored low address bits.
    bus_wr(32'h0000_0010, 32'hDEAD_BEEF);
    bus_rd(32'h0000_0010, v); chk("ram_rd", v, 32'hDEAD_BEEF);
    bus_rd(32'h0000_1010, v); chk("ram_alias", v, 32'hDEAD_BEEF);
    bus_wr(32'h0000_0014, 32'h1234_5678);
    bus_rd(32'h0000_0017, v); chk("ram_lowbits", v, 32'h1234_5678);
    bus_rd(32'h0000_0010, v); chk("ram_keep", v, 32'hDEAD_BEEF);

    // rdata gated to zero on idle or write cycles.
    ce = 1'b0; we = 1'b0; addr = 32'h0000_0010; #1;
    chk("rdata_idle", rdata, 32'h0);
    ce = 1'b1; we = 1'b1; wdata = 32'hDEAD_BEEF; #1;
    chk("rdata_wr", rdata, 32'h0);
    ce = 1'b0; we = 1'b0;

    // MMIO: LED RW, SWITCH RO, unmapped offset.
    bus_wr(A_LED, 32'h0000_00A5);
    chk("led_out", led, 32'h0000_00A5);
    bus_rd(A_LED, v); chk("rd_led", v, 32'h0000_00A5);
    bus_wr(A_SW, 32'h0000_0FFF);
    bus_rd(A_SW, v); chk("sw_ro", v, 32'h0);
    bus_wr(32'hFFFF_F0FC, 32'h5555_AAAA);
    bus_rd(32'hFFFF_F0FC, v); chk("unmapped", v, 32'h0);
    chk("led_after_unmapped", led, 32'h0000_00A5);

    // Debounce, CYCLES=8: change visible exactly 10 edges after the pin moves.
    sw_raw = 12'h0F0;
    tick(9);
    chk("deb_edge9", {20'b0, sw_stable}, 32'h0);
    tick();
    chk("deb_edge10", {20'b0, sw_stable}, 32'h0F0);
    bus_rd(A_SW, v); chk("rd_sw_deb", v, 32'h0F0);

    // 5-cycle glitch on bit 0 must be rejected.
    sw_raw = 12'h0F1;
    tick(5);
    sw_raw = 12'h0F0;
    tick(20);
    chk("deb_glitch", {20'b0, sw_stable}, 32'h0F0);

    sw_raw = 12'h000;
    tick(10);
    chk("deb_release", {20'b0, sw_stable}, 32'h0);

`ifdef DBUS_TIMER_EN
    bus_wr(A_TMR, 32'hFFFF_FFFE);
    bus_rd(A_TMR, v); chk("tmr_p1", v, 32'hFFFF_FFFE);
    tick();
    bus_rd(A_TMR, v); chk("tmr_p2", v, 32'hFFFF_FFFF);
    tick();
    bus_rd(A_TMR, v); chk("tmr_wrap", v, 32'h0);
    tick(5);
    bus_rd(A_TMR, v); chk("tmr_run", v, 32'h5);
`else
    bus_wr(A_TMR, 32'hFFFF_FFFE);
    bus_rd(A_TMR, v); chk("tmr_off_p1", v, 32'h0);
    tick(3);
    bus_rd(A_TMR, v); chk("tmr_off_p4", v, 32'h0);
`endif

    // Reset dropped during an LED write: reset value appears at once, write lost.
    ce = 1'b1; we = 1'b1; addr = A_LED; wdata = 32'h0000_0055;
    #2 rst = 1'b0;
    #1 chk("rst_mid_led", led, LED_RST);
    tick();
    chk("rst_mid_led_edge", led, LED_RST);
    we = 1'b0; #1;
    chk("rst_mid_rdata", rdata, LED_RST);
    ce = 1'b0;
    rst = 1'b1;
    tick();
    chk("led_after_rst", led, LED_RST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_bus_slave.md
Name: data_bus_slave

Overview:
- Responder for the core's data-memory port (ram_ce/ram_we/ram_addr/ram_data).
- Contains:
  - word-addressed data RAM;
  - memory-mapped LED output register;
  - debounced 12-bit switch input;
  - free-running cycle timer.
- Sits beside jz_core at SoC top: core ram_* outputs drive this block; its rdata drives core ram_data_i.
- Physical switches enter here, not the core. The core's own switch_on/led_out ports are tied off at top.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words (power of two).
- DEBOUNCE_CYCLES, 20'd1000000, cycles a synchronized switch bit must be stable before it is accepted (≥2).
- LED_RESET, 32'h0000_0000, LED register reset value.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- ce  in  1  bus access strobe (core ram_ce_o).
- we  in  1  write enable, qualified by ce (core ram_we_o).
- addr  in  32  byte address (core ram_addr_o); bits [1:0] ignored.
- wdata  in  32  write data (core ram_data_o).
- rdata  out  32  read data (to core ram_data_i), combinational.
- sw_raw  in  12  asynchronous switch pins.
- led  out  32  LED register.
- sw_stable  out  12  debounced switch value (debug/visibility).

Behaviour:
- Address decode, on addr[31:2] only:
  - `DbusMmioBase (32'hFFFF_F000) + 0x0: LED register, RW.
  - +0x4: SWITCH, RO = {20'b0, sw_stable}.
  - +0x8: TIMER, RW.
  - Any other address with addr[31:12] != 20'hFFFFF: RAM at index addr[2+log2(RAM_WORDS)-1:2] (aliasing above depth is intended).
  - Unmapped MMIO offsets: read 32'h0, writes dropped.
- Reads:
  - Combinational, zero-wait: rdata valid in the same cycle ce=1, we=0, because the core's MEM stage samples it combinationally.
  - rdata = 32'h0 when ce=0 or we=1.
- Writes:
  - Take effect at the rising edge where ce=1 and we=1.
  - A read of the same address in the next cycle returns the new value. No same-cycle bypass is needed since read and write never coincide.
- RAM is not reset (contents undefined after reset). All registers reset asynchronously on rst=0:
  - led = LED_RESET; sw_stable = 0; timer = 0; sync flops = 0; debounce counters = 0.
- Switch path:
  - 2-flop synchronizer per bit, then per-bit counter.
  - If the synced bit equals sw_stable bit, clear its counter.
  - Otherwise increment; when the counter reaches DEBOUNCE_CYCLES-1, update the sw_stable bit and clear the counter.
  - Latency from a clean pin edge to sw_stable change = 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES resets the counter and produces no change.
- Timer:
  - Increments by 1 every cycle, wraps 32'hFFFF_FFFF -> 0.
  - A bus write loads wdata; the increment resumes the following cycle, so a read at write+1 sees wdata, at write+2 sees wdata+1.
  - A write takes priority over the increment in that cycle.
- Reset asserted mid-access:
  - Any write in flight is lost.
  - rdata for MMIO reflects reset values immediately (async).
- No handshake or back-pressure: the block never stalls the core.

Optional Feature:
- Macro DBUS_TIMER_EN.
- Defined: TIMER register present as above.
- Undefined: no timer flops synthesized; offset 0x8 reads 32'h0, writes dropped, decode otherwise unchanged.

Decomposition:
- Add the following to defines.v: `DbusMmioBase, `DbusLedOff (12'h000), `DbusSwOff (12'h004), `DbusTimerOff (12'h008). Reuse `RegBus for 32-bit width.
- One sub-module, sw_debounce: parameter WIDTH, CYCLES; ports clk, rst, din, dout. It holds the synchronizer and the per-bit counters.
- RAM array, decode and timer stay in data_bus_slave.

Test Plan:
- Reset, then read LED/SWITCH/TIMER with sw_raw=0 -> rdata 0, 0, small count; led=LED_RESET.
- Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 next cycle -> 0xDEADBEEF. Read 0x0000_1010 with RAM_WORDS=1024 -> 0xDEADBEEF (alias).
- Write 0x0000_00A5 to 0xFFFF_F000 -> led=0x0000_00A5 after that edge. Write to 0xFFFF_F004 -> SWITCH unchanged.
- DEBOUNCE_CYCLES=8:
  - sw_raw=12'h0F0 held -> sw_stable=12'h0F0 exactly 10 cycles later.
  - 5-cycle pulse 12'h001 -> sw_stable unchanged.
- DBUS_TIMER_EN set:
  - Write 0xFFFF_FFFE to TIMER, read at +1, +2, +3 -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
  - Macro unset -> all reads 0.
- Drop rst mid-write to LED (ce=we=1) -> led=LED_RESET immediately, write not applied. Read of unmapped 0xFFFF_F0FC -> 0.
